fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised successor to the single-cycle fetch stage: owns the PC and a DEPTH-entry prefetch FIFO between instruction memory and decode. The FIFO decouples decode stalls from instruction fetch and delivers {pc, instr} pairs in program order. Execute-stage redirects (branch / JALR) flush it. Sits in the IF stage, feeding the IF/ID register, and drives an external combinational instruction memory.

## Interface
- DATA_WIDTH, 32, instruction and address width
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  input  1  clock
- rst  input  1  reset; synchronous and active-high (one clock; polarity and synchronicity fixed)
- en  input  1  decode accepts head entry this cycle (0 = decode stall)
- branchE  input  1  taken branch/JAL in execute; redirect to pc_targetE
- jalrinsE  input  1  JALR in execute; redirect to alu_outE
- pc_targetE  input  DATA_WIDTH  branch/JAL target
- alu_outE  input  DATA_WIDTH  JALR target, before bit-0 clear
- imem_addr  output  DATA_WIDTH  fetch address to instruction memory
- imem_data  input  DATA_WIDTH  instruction at imem_addr, same cycle
- validF  output  1  head entry valid
- instrF  output  DATA_WIDTH  head instruction
- pcF  output  DATA_WIDTH  head PC
- pc_plus4F  output  DATA_WIDTH  pcF + 4
- countF  output  $clog2(DEPTH)+1  FIFO occupancy
- perf_fetched, perf_redirects, perf_full  output  32 each  performance counters (see Configuration)

## Operation
- Fetch PC register fpc drives imem_addr directly.
- Enqueue condition: no redirect, and (count < DEPTH or en && validF). On enqueue, write {fpc, imem_data} at the tail and set fpc <= fpc + 4 (mod 2^DATA_WIDTH).
- Dequeue condition: en && validF && no redirect. Pop the head.
- Head outputs: when count > 0, drive validF=1 and the head entry. When empty, drive validF=0, instrF=NOP (32'h0000_0013), pcF=0, pc_plus4F=4.
- Redirect when branchE || jalrinsE. jalrinsE has priority: target = alu_outE & ~1. Otherwise target = pc_targetE.
- On redirect, in the same edge: count <= 0, pointers <= 0, fpc <= target. No enqueue or dequeue that cycle.
- Boundary conditions:
  - Full and en: enqueue and dequeue together; count unchanged.
  - Empty and en: no-op.
  - Pointers wrap modulo DEPTH.
  - Redirect with en: flush wins; the head is not consumed.
  - rst overrides everything, including mid-flush.
- Reset values: fpc=RESET_PC, count=0, pointers=0, validF=0, instrF=NOP, pcF=0, pc_plus4F=4, counters=0.

## Timing
- Memory read is combinational; the FIFO write is registered. An instruction addressed in cycle N is visible at the head in cycle N+1 at the earliest.
- After reset release (cycle 0): imem_addr=RESET_PC; validF=1 from cycle 1.
- Redirect in cycle N:
  - N+1: imem_addr=target, validF=0.
  - N+2: validF=1, pcF=target.
- Sustained throughput is 1 instr/cycle with en=1. With en=0, the FIFO fills in DEPTH cycles and fpc then holds.
- Head outputs are registered-storage reads with no path from imem_data. Dequeue, enqueue and flush take effect at the rising edge.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - perf_fetched increments on each enqueue.
  - perf_redirects increments on each redirect.
  - perf_full increments each cycle count==DEPTH and no dequeue.
  - All counters are 32-bit and wrap; cleared by rst.
- Undefined: counter logic is absent and the three ports are tied to 0. Ports remain so the integration is identical.

## Structure
- Package fetch_pkg:
  - NOP_INSTR constant.
  - fetch_entry_t struct {pc, instr}.
  - Redirect-target function (JALR bit-0 clear, priority select).
- Sub-module fetch_fifo:
  - Parametrised by DEPTH and entry type.
  - Ports: push, pop, flush, count, head.
- fetch_queue holds fpc, the redirect mux and the perf counters.

## Test plan
- Reset, en=1 for 6 cycles, imem returns addr^32'hA5A5_0000 → pcF sequence 0,4,8,12,16 from cycle 1; validF=1; instrF matches.
- en=0 for 8 cycles from reset → countF saturates at 4 by cycle 4; imem_addr holds 16; on en=1, pcF=0,4,8,12,16 with no gap.
- branchE=1, pc_targetE=0x100 at cycle 5 with FIFO half full → cycle 6 validF=0, countF=0; cycle 7 pcF=0x100, pc_plus4F=0x104.
- branchE=1 and jalrinsE=1 together, pc_targetE=0x200, alu_outE=0x301 → fetch resumes at 0x300.
- rst asserted mid-stream with FIFO full → next cycle validF=0, instrF=0x13, imem_addr=RESET_PC.
- FETCH_PERF_CNT_EN defined, 10 enqueues, 2 redirects, 3 full-stall cycles → counters read 10, 2, 3. Undefined → all 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, entry type and redirect-target helper for the fetch queue.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] redirect_target(
    input logic            jalr,
    input logic [XLEN-1:0] pc_target,
    input logic [XLEN-1:0] alu_out
  );
    return jalr ? {alu_out[XLEN-1:1], 1'b0} : pc_target;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two circular FIFO with flush; head is a registered-storage read.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  T                       din,
  output T                       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  T              mem_q [DEPTH];
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= push ? wr_q + AW'(1) : wr_q;
      rd_q  <= pop ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_d;
    end
  end
  // When full, push and pop hit the same slot; the old head is read before the edge.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign head  = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: IF stage owning the fetch PC and a DEPTH-entry prefetch FIFO toward decode.
// Define FETCH_PERF_CNT_EN to build the perf counters; otherwise they are tied to 0.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = XLEN,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   branchE,
  input  logic                   jalrinsE,
  input  logic [DATA_WIDTH-1:0]  pc_targetE,
  input  logic [DATA_WIDTH-1:0]  alu_outE,
  output logic [DATA_WIDTH-1:0]  imem_addr,
  input  logic [DATA_WIDTH-1:0]  imem_data,
  output logic                   validF,
  output logic [DATA_WIDTH-1:0]  instrF,
  output logic [DATA_WIDTH-1:0]  pcF,
  output logic [DATA_WIDTH-1:0]  pc_plus4F,
  output logic [$clog2(DEPTH):0] countF,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_redirects,
  output logic [31:0]            perf_full
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic                  redirect, enq, deq, full;
  logic [DATA_WIDTH-1:0] fpc_q, fpc_d;
  fetch_entry_t          head, tail;
  assign redirect = branchE | jalrinsE;
  assign full     = countF == CW'(DEPTH);
  assign validF   = countF != '0;
  assign deq      = en & validF & ~redirect;
  assign enq      = ~redirect & (~full | deq);
  assign fpc_d    = redirect ? redirect_target(jalrinsE, pc_targetE, alu_outE) :
                    enq      ? fpc_q + DATA_WIDTH'(4) : fpc_q;
  always_ff @(posedge clk) begin
    fpc_q <= rst ? RESET_PC : fpc_d;
  end
  assign imem_addr = fpc_q;
  assign tail      = '{pc: fpc_q, instr: imem_data};
  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (enq),
    .pop  (deq),
    .flush(redirect),
    .din  (tail),
    .head (head),
    .count(countF)
  );
  assign instrF    = validF ? head.instr : NOP_INSTR;
  assign pcF       = validF ? head.pc : '0;
  assign pc_plus4F = pcF + DATA_WIDTH'(4);
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, redirects_q, full_q;
  always_ff @(posedge clk) begin
    fetched_q   <= rst ? '0 : fetched_q + 32'(enq);
    redirects_q <= rst ? '0 : redirects_q + 32'(redirect);
    full_q      <= rst ? '0 : full_q + 32'(full & ~deq);
  end
  assign perf_fetched   = fetched_q;
  assign perf_redirects = redirects_q;
  assign perf_full      = full_q;
`else
  assign perf_fetched   = '0;
  assign perf_redirects = '0;
  assign perf_full      = '0;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus checked each cycle against a queue-based model.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;
  logic clk = 0, rst = 1, en = 0, branchE = 0, jalrinsE = 0;
  logic [31:0] pc_targetE = 0, alu_outE = 0;
  logic [31:0] imem_addr, imem_data, instrF, pcF, pc_plus4F;
  logic [31:0] perf_fetched, perf_redirects, perf_full;
  logic        validF;
  logic [$clog2(DEPTH):0] countF;
  always #5 clk = ~clk;
  assign imem_data = imem_addr ^ KEY;
  fetch_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .en(en), .branchE(branchE), .jalrinsE(jalrinsE),
    .pc_targetE(pc_targetE), .alu_outE(alu_outE), .imem_addr(imem_addr),
    .imem_data(imem_data), .validF(validF), .instrF(instrF), .pcF(pcF),
    .pc_plus4F(pc_plus4F), .countF(countF), .perf_fetched(perf_fetched),
    .perf_redirects(perf_redirects), .perf_full(perf_full)
  );
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        q[$];
  logic [31:0] m_fpc = RPC, m_fet = 0, m_red = 0, m_full = 0;
  int          n_chk = 0, n_fail = 0;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_step(logic e, logic b, logic j, logic [31:0] pt, logic [31:0] ao, logic r);
    bit deq, enq;
    if (r) begin
      q.delete();
      m_fpc = RPC; m_fet = 0; m_red = 0; m_full = 0;
    end else begin
      deq = !(b || j) && e && q.size() > 0;
      if (q.size() == DEPTH && !deq) m_full++;
      if (b || j) begin
        q.delete();
        m_fpc = j ? (ao & ~32'd1) : pt;
        m_red++;
      end else begin
        enq = q.size() < DEPTH || deq;
        if (deq) void'(q.pop_front());
        if (enq) begin
          q.push_back('{m_fpc, m_fpc ^ KEY});
          m_fpc += 4;
          m_fet++;
        end
      end
    end
  endtask
  task automatic compare();
    logic [31:0] epc, einstr;
    epc = 0; einstr = NOP;
    if (q.size() > 0) begin epc = q[0].pc; einstr = q[0].instr; end
    chk("imem_addr", imem_addr, m_fpc);
    chk("validF", 32'(validF), 32'(q.size() > 0));
    chk("instrF", instrF, einstr);
    chk("pcF", pcF, epc);
    chk("pc_plus4F", pc_plus4F, epc + 4);
    chk("countF", 32'(countF), q.size());
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fet);
    chk("perf_redirects", perf_redirects, m_red);
    chk("perf_full", perf_full, m_full);
`else
    chk("perf_fetched", perf_fetched, 0);
    chk("perf_redirects", perf_redirects, 0);
    chk("perf_full", perf_full, 0);
`endif
  endtask
  task automatic cycle(logic e, logic b = 0, logic j = 0, logic [31:0] pt = 0,
                       logic [31:0] ao = 0, logic r = 0);
    en = e; branchE = b; jalrinsE = j; pc_targetE = pt; alu_outE = ao; rst = r;
    model_step(e, b, j, pt, ao, r);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask
  initial begin
    @(negedge clk);
    // streaming with en=1 from reset
    cycle(0, .r(1));
    chk("A_addr0", imem_addr, RPC);
    chk("A_valid0", 32'(validF), 0);
    chk("A_instr0", instrF, 32'h13);
    chk("A_plus4_0", pc_plus4F, 32'h4);
    for (int k = 1; k <= 5; k++) begin
      cycle(1);
      chk("A_pc", pcF, 32'(4 * (k - 1)));
      chk("A_instr", instrF, 32'(4 * (k - 1)) ^ 32'hA5A5_0000);
      chk("A_valid", 32'(validF), 1);
    end
    // fill with en=0, then drain without a gap
    cycle(0, .r(1));
    for (int k = 1; k <= 8; k++) begin
      cycle(0);
      if (k == 4) chk("B_count4", 32'(countF), 4);
    end
    chk("B_addr_hold", imem_addr, 32'd16);
    chk("B_count_sat", 32'(countF), 4);
    chk("B_pc0", pcF, 0);
    for (int k = 1; k <= 4; k++) begin
      cycle(1);
      chk("B_pc", pcF, 32'(4 * k));
      chk("B_valid", 32'(validF), 1);
    end
    // branch flush with FIFO half full
    cycle(0, .r(1));
    cycle(0);
    cycle(0);
    chk("C_half", 32'(countF), 2);
    cycle(1, 1, 0, 32'h100, 0);
    chk("C_valid0", 32'(validF), 0);
    chk("C_count0", 32'(countF), 0);
    chk("C_addr", imem_addr, 32'h100);
    cycle(1);
    chk("C_pc", pcF, 32'h100);
    chk("C_plus4", pc_plus4F, 32'h104);
    // JALR wins over branch and clears bit 0
    cycle(1, 1, 1, 32'h200, 32'h301);
    chk("D_addr", imem_addr, 32'h300);
    cycle(1);
    chk("D_pc", pcF, 32'h300);
    // reset with a full FIFO
    for (int k = 0; k < 5; k++) cycle(0);
    chk("E_full", 32'(countF), 4);
    cycle(1, .r(1));
    chk("E_valid", 32'(validF), 0);
    chk("E_instr", instrF, 32'h13);
    chk("E_addr", imem_addr, RPC);
    // perf counters: 10 enqueues, 2 redirects, 3 full-stall cycles
    cycle(0, .r(1));
    cycle(0); cycle(0);
    cycle(0, 1, 0, 32'h40, 0);
    cycle(0); cycle(0);
    cycle(0, 0, 1, 0, 32'h81);
    for (int k = 0; k < 7; k++) cycle(0);
    cycle(1); cycle(1);
`ifdef FETCH_PERF_CNT_EN
    chk("F_fetched", perf_fetched, 10);
    chk("F_redirects", perf_redirects, 2);
    chk("F_full", perf_full, 3);
`else
    chk("F_fetched", perf_fetched, 0);
    chk("F_redirects", perf_redirects, 0);
    chk("F_full", perf_full, 0);
`endif
    // random traffic, including targets near the top of the address space
    for (int k = 0; k < 500; k++) begin
      logic [31:0] pt, ao;
      pt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & ~32'd3);
      ao = $urandom;
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 5, pt, ao, $urandom_range(0, 99) < 2);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
